mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as below.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 resetn  in  1  reset, asynchronous and active-low.
REQ-004 es_to_ms_valid  in  1  the EX stage offers an instruction.
REQ-005 es_to_ms_bus  in  154  MSB-to-LSB fields: rt_value[32], eret, res_from_cp0, cp0_addr[5], mtc0_we, bd, badvaddr[32], excode[5], ex, req_issued, ld_type[3], res_from_mem, dest[5], gr_we, alu_result[32], pc[32].
REQ-006 ms_allowin  out  1  the MEM stage accepts this cycle.
REQ-007 ws_allowin  in  1  the WB stage accepts this cycle.
REQ-008 ms_to_ws_valid  out  1  the MEM stage offers an instruction to WB.
REQ-009 ms_to_ws_bus  out  149  MSB-to-LSB fields: rt_value[32], eret, bd, mtc0_we, cp0_addr[5], res_from_cp0, badvaddr[32], ex, excode[5], gr_we, dest[5], final_result[32], pc[32].
REQ-010 ws_flush  in  1  exception or ERET is committing in WB; the pipeline flushes.
REQ-011 data_sram_data_ok  in  1  one data-RAM response this cycle.
REQ-012 data_sram_rdata  in  32  response data, valid when data_ok=1.
REQ-013 ms_fwd_bus  out  39  fields: {we, pending, dest[5], result[32]} for ID hazard and forwarding logic.

Function
REQ-014 ms_valid SHALL load es_to_ms_valid when ms_allowin=1, and the bus register SHALL load es_to_ms_bus when es_to_ms_valid && ms_allowin.
REQ-015 ms_allowin SHALL equal !ms_valid || (ms_ready_go && ws_allowin).
REQ-016 ms_to_ws_valid SHALL equal ms_valid && ms_ready_go && !ws_flush.
REQ-017 need_data SHALL equal req_issued && !ex; ms_ready_go SHALL equal !need_data || got_data, where got_data = rbuf_valid || (data_ok && discard_cnt==0).
REQ-018 A data_ok arriving while discard_cnt>0 SHALL decrement discard_cnt and SHALL be otherwise ignored.
REQ-019 A data_ok accepted while ms_valid && need_data && !ws_allowin SHALL set rbuf_valid and capture the data in rbuf.
REQ-020 rbuf_valid SHALL clear when the instruction moves to WB or on ws_flush.
REQ-021 Data selection: raw = rbuf_valid ? rbuf : data_sram_rdata.
REQ-022 Alignment: a = alu_result[1:0].
REQ-023 ld_type 000 (lw) SHALL return raw.
REQ-024 ld_type 001/010 (lb/lbu) SHALL return byte raw[8a+7:8a], sign- or zero-extended respectively.
REQ-025 ld_type 011/100 (lh/lhu) SHALL return halfword raw[16a[1]+15:16a[1]], sign- or zero-extended respectively.
REQ-026 Other ld_type codes SHALL return raw.
REQ-027 final_result SHALL be the aligned load data when res_from_mem=1, else alu_result.
REQ-028 All other ms_to_ws_bus fields SHALL pass through unchanged from the bus register.
REQ-029 On ws_flush, ms_valid SHALL clear the next cycle regardless of ws_allowin, and an incoming es_to_ms_valid SHALL NOT be latched that cycle.
REQ-030 On ws_flush while ms_valid && need_data && !got_data, discard_cnt SHALL increment by 1 (saturate at 3).
REQ-031 When the flush and the data_ok for that same instruction coincide, the response SHALL be counted as consumed: no increment and no decrement.
REQ-032 ms_fwd_bus.we SHALL equal ms_valid && gr_we && !ex; pending SHALL equal ms_valid && res_from_mem && !ms_ready_go; dest SHALL be the bus dest; result SHALL equal final_result.
REQ-033 Latency: non-load instructions SHALL reach WB one cycle after acceptance; loads SHALL reach WB in the same cycle data_ok is accepted (or the cycle ws_allowin rises, from rbuf).

Reset
REQ-034 While resetn=0, ms_valid, rbuf_valid, discard_cnt and rbuf SHALL be 0, so ms_to_ws_valid=0, ms_allowin=1 and ms_fwd_bus.we=0 and pending=0.
REQ-035 A reset asserted mid-wait SHALL drop the outstanding request without tracking it; the memory side is reset concurrently.

Verification
REQ-036 Scenario: lb with alu_result=0x1003 and rdata=0x80FF_FF7F returned 2 cycles late -> pending=1 for 2 cycles, then final_result=0xFFFF_FF80 and ms_to_ws_valid=1 for exactly 1 cycle.
REQ-037 Scenario: lhu with a=2 and rdata=0x8001_1234 -> final_result=0x0000_8001.
REQ-038 Scenario: data_ok arrives while ws_allowin=0 for 3 cycles -> rbuf holds the data, no re-request is made, and WB receives the correct value when ws_allowin=1.
REQ-039 Scenario: ws_flush while a lw waits -> ms_valid=0 next cycle and discard_cnt=1; the stale data_ok is dropped; the next lw gets its own data.
REQ-040 Scenario: add (alu_result=5, dest=3) back-to-back with ws_allowin=1 -> one instruction per cycle, and ms_fwd_bus={1,0,3,5}.
REQ-041 Scenario: ex=1 with req_issued=1 -> no wait; the instruction passes to WB in 1 cycle with ex and excode intact.

Source files
------------

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - MEM stage pipeline, data-RAM response and forwarding signals
interface mem_stage_if;
    logic         es_to_ms_valid;
    logic [153:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [148:0] ms_to_ws_bus;
    logic         ws_flush;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [38:0]  ms_fwd_bus;

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin, ws_flush,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin, ws_flush,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load response wait, buffering, flush discard and alignment
module mem_stage (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave bus
);
    logic         ms_valid;
    logic [153:0] ms_bus_r;
    logic         rbuf_valid;
    logic [31:0]  rbuf;
    logic [1:0]   discard_cnt;

    logic [31:0] rt_value, badvaddr, alu_result, pc;
    logic        eret, res_from_cp0, mtc0_we, bd, ex, req_issued, res_from_mem, gr_we;
    logic [4:0]  cp0_addr, excode, dest;
    logic [2:0]  ld_type;

    assign {rt_value, eret, res_from_cp0, cp0_addr, mtc0_we, bd, badvaddr, excode, ex,
            req_issued, ld_type, res_from_mem, dest, gr_we, alu_result, pc} = ms_bus_r;

    logic need_data, data_live, got_data, ms_ready_go, to_ws_fire;
    logic disc_inc, disc_dec;

    // A response is ours only once every response owed to flushed loads has drained.
    assign need_data   = req_issued && !ex;
    assign data_live   = bus.data_sram_data_ok && (discard_cnt == 2'd0);
    assign got_data    = rbuf_valid || data_live;
    assign ms_ready_go = !need_data || got_data;

    assign bus.ms_allowin     = !ms_valid || (ms_ready_go && bus.ws_allowin);
    assign bus.ms_to_ws_valid = ms_valid && ms_ready_go && !bus.ws_flush;
    assign to_ws_fire         = bus.ms_to_ws_valid && bus.ws_allowin;

    assign disc_inc = bus.ws_flush && ms_valid && need_data && !got_data;
    assign disc_dec = bus.data_sram_data_ok && (discard_cnt != 2'd0);

    logic [31:0] raw, load_data, final_result;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        raw       = rbuf_valid ? rbuf : bus.data_sram_rdata;
        byte_sel  = raw[{alu_result[1:0], 3'b000} +: 8];
        half_sel  = alu_result[1] ? raw[31:16] : raw[15:0];
        load_data = raw;
        case (ld_type)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_data = {24'd0, byte_sel};
            3'b011:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {16'd0, half_sel};
            default: load_data = raw;
        endcase
        final_result = res_from_mem ? load_data : alu_result;
    end

    assign bus.ms_to_ws_bus = {rt_value, eret, bd, mtc0_we, cp0_addr, res_from_cp0, badvaddr,
                               ex, excode, gr_we, dest, final_result, pc};

    assign bus.ms_fwd_bus = {ms_valid && gr_we && !ex,
                             ms_valid && res_from_mem && !ms_ready_go,
                             dest, final_result};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            ms_bus_r <= '0;
        end else begin
            if (bus.ws_flush)
                ms_valid <= 1'b0;
            else if (bus.ms_allowin)
                ms_valid <= bus.es_to_ms_valid;
            if (bus.es_to_ms_valid && bus.ms_allowin && !bus.ws_flush)
                ms_bus_r <= bus.es_to_ms_bus;
        end
    end

    // Hold a response that arrived while WB was stalled so no re-request is needed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rbuf_valid <= 1'b0;
            rbuf       <= 32'd0;
        end else if (bus.ws_flush || to_ws_fire) begin
            rbuf_valid <= 1'b0;
        end else if (ms_valid && need_data && data_live && !bus.ws_allowin && !rbuf_valid) begin
            rbuf_valid <= 1'b1;
            rbuf       <= bus.data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            discard_cnt <= 2'd0;
        else if (disc_inc && !disc_dec && discard_cnt != 2'd3)
            discard_cnt <= discard_cnt + 2'd1;
        else if (disc_dec && !disc_inc)
            discard_cnt <= discard_cnt - 2'd1;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - table-driven and scoreboard bench for mem_stage
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if intf();
    mem_stage dut (.clk(clk), .resetn(resetn), .bus(intf));

    typedef struct packed {
        logic [31:0] rt_value;
        logic        eret;
        logic        res_from_cp0;
        logic [4:0]  cp0_addr;
        logic        mtc0_we;
        logic        bd;
        logic [31:0] badvaddr;
        logic [4:0]  excode;
        logic        ex;
        logic        req_issued;
        logic [2:0]  ld_type;
        logic        res_from_mem;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } ins_t;

    typedef struct {
        ins_t        ins;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_res;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [148:0] sb[$];
    logic [148:0] mon_exp;
    vec_t vecs[12];
    ins_t ins;

    task automatic chkw(input string name, input logic [148:0] act, input logic [148:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chkw(name, 149'(act), 149'(exp));
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chkw(name, 149'(act), 149'(exp));
    endtask

    function automatic ins_t mk(input logic [2:0] ld, input logic rfm, input logic req,
                                input logic exf, input logic [31:0] alu, input int idx);
        ins_t t;
        t.rt_value     = 32'hA500_0000 + 32'(idx);
        t.eret         = idx[0];
        t.res_from_cp0 = idx[1];
        t.cp0_addr     = idx[4:0] + 5'd7;
        t.mtc0_we      = idx[2];
        t.bd           = idx[0] ^ idx[1];
        t.badvaddr     = alu ^ 32'hFFFF_0000;
        t.excode       = exf ? 5'h04 : 5'h00;
        t.ex           = exf;
        t.req_issued   = req;
        t.ld_type      = ld;
        t.res_from_mem = rfm;
        t.dest         = 5'(idx + 1);
        t.gr_we        = 1'b1;
        t.alu_result   = alu;
        t.pc           = 32'hBFC0_0000 + 32'(idx * 4);
        return t;
    endfunction

    function automatic logic [148:0] exp_bus(input ins_t t, input logic [31:0] fin);
        return {t.rt_value, t.eret, t.bd, t.mtc0_we, t.cp0_addr, t.res_from_cp0, t.badvaddr,
                t.ex, t.excode, t.gr_we, t.dest, fin, t.pc};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic need;
        need = v.ins.req_issued && !v.ins.ex;
        cyc();
        intf.es_to_ms_valid    = 1'b1;
        intf.es_to_ms_bus      = v.ins;
        intf.data_sram_data_ok = 1'b0;
        intf.data_sram_rdata   = v.rdata;
        sb.push_back(exp_bus(v.ins, v.exp_res));
        #1 chk1("allowin_issue", intf.ms_allowin, 1'b1);
        cyc();
        intf.es_to_ms_valid = 1'b0;
        if (need) begin
            for (int d = 0; d < v.delay; d++) begin
                #1 chk1("pending_wait", intf.ms_fwd_bus[37], v.ins.res_from_mem);
                chk1("no_early_out", intf.ms_to_ws_valid, 1'b0);
                cyc();
            end
            intf.data_sram_data_ok = 1'b1;
        end
        #1 chk1("out_valid", intf.ms_to_ws_valid, 1'b1);
        chk1("pending_done", intf.ms_fwd_bus[37], 1'b0);
        cyc();
        intf.data_sram_data_ok = 1'b0;
        #1 chk1("out_one_cycle", intf.ms_to_ws_valid, 1'b0);
    endtask

    // Scoreboard: every transfer into WB must match the oldest pushed expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && intf.ms_to_ws_valid && intf.ws_allowin) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no transfer", intf.ms_to_ws_bus);
                end else begin
                    mon_exp = sb.pop_front();
                    chkw("ws_bus", intf.ms_to_ws_bus, mon_exp);
                end
            end
        end
    end

    initial begin
        resetn                 = 1'b0;
        intf.es_to_ms_valid    = 1'b0;
        intf.es_to_ms_bus      = '0;
        intf.ws_allowin        = 1'b1;
        intf.ws_flush          = 1'b0;
        intf.data_sram_data_ok = 1'b0;
        intf.data_sram_rdata   = 32'd0;

        vecs[0]  = '{mk(3'b000, 1, 1, 0, 32'h0000_1000, 0),  32'h1234_5678, 1, 32'h1234_5678};
        vecs[1]  = '{mk(3'b001, 1, 1, 0, 32'h0000_1003, 1),  32'h80FF_FF7F, 2, 32'hFFFF_FF80};
        vecs[2]  = '{mk(3'b010, 1, 1, 0, 32'h0000_1001, 2),  32'h80FF_FF7F, 0, 32'h0000_00FF};
        vecs[3]  = '{mk(3'b001, 1, 1, 0, 32'h0000_1000, 3),  32'h80FF_FF7F, 1, 32'h0000_007F};
        vecs[4]  = '{mk(3'b011, 1, 1, 0, 32'h0000_2002, 4),  32'h8001_1234, 0, 32'hFFFF_8001};
        vecs[5]  = '{mk(3'b100, 1, 1, 0, 32'h0000_2002, 5),  32'h8001_1234, 1, 32'h0000_8001};
        vecs[6]  = '{mk(3'b011, 1, 1, 0, 32'h0000_2000, 6),  32'h0000_F00F, 3, 32'hFFFF_F00F};
        vecs[7]  = '{mk(3'b101, 1, 1, 0, 32'h0000_3001, 7),  32'hCAFE_BABE, 0, 32'hCAFE_BABE};
        vecs[8]  = '{mk(3'b001, 1, 1, 0, 32'h0000_0002, 8),  32'h12B4_5678, 1, 32'hFFFF_FFB4};
        vecs[9]  = '{mk(3'b000, 0, 0, 0, 32'h0000_0005, 9),  32'hDEAD_0000, 0, 32'h0000_0005};
        vecs[10] = '{mk(3'b000, 1, 1, 1, 32'h0000_1001, 10), 32'hDEAD_0000, 0, 32'hDEAD_0000};
        vecs[11] = '{mk(3'b100, 0, 1, 0, 32'h0000_0044, 11), 32'h1111_2222, 1, 32'h0000_0044};

        cyc();
        #1 chk1("rst_to_ws_valid", intf.ms_to_ws_valid, 1'b0);
        chk1("rst_allowin", intf.ms_allowin, 1'b1);
        chk1("rst_fwd_we", intf.ms_fwd_bus[38], 1'b0);
        chk1("rst_fwd_pending", intf.ms_fwd_bus[37], 1'b0);
        cyc();
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        for (int k = 0; k < 3; k++) begin
            cyc();
            ins = mk(3'b000, 0, 0, 0, 32'd5, 20 + k);
            ins.dest = 5'd3;
            intf.es_to_ms_valid = 1'b1;
            intf.es_to_ms_bus   = ins;
            sb.push_back(exp_bus(ins, 32'd5));
            #1 chk1("b2b_allowin", intf.ms_allowin, 1'b1);
            if (k > 0) begin
                chkw("b2b_fwd", 149'(intf.ms_fwd_bus), 149'({1'b1, 1'b0, 5'd3, 32'd5}));
                chk1("b2b_out", intf.ms_to_ws_valid, 1'b1);
            end
        end
        cyc();
        intf.es_to_ms_valid = 1'b0;
        #1 chkw("b2b_fwd_last", 149'(intf.ms_fwd_bus), 149'({1'b1, 1'b0, 5'd3, 32'd5}));
        cyc();
        #1 chk1("b2b_drain", intf.ms_to_ws_valid, 1'b0);

        cyc();
        ins = mk(3'b000, 1, 1, 0, 32'h0000_0010, 30);
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = ins;
        sb.push_back(exp_bus(ins, 32'h55AA_33CC));
        cyc();
        intf.es_to_ms_valid    = 1'b0;
        intf.ws_allowin        = 1'b0;
        intf.data_sram_data_ok = 1'b1;
        intf.data_sram_rdata   = 32'h55AA_33CC;
        #1 chk1("rbuf_allowin_stall", intf.ms_allowin, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            intf.data_sram_data_ok = 1'b0;
            intf.data_sram_rdata   = 32'hFFFF_FFFF;
            #1 chk1("rbuf_pending", intf.ms_fwd_bus[37], 1'b0);
            chk32("rbuf_result", intf.ms_fwd_bus[31:0], 32'h55AA_33CC);
            chk1("rbuf_hold", intf.ms_allowin, 1'b0);
        end
        cyc();
        intf.ws_allowin = 1'b1;
        #1 chk1("rbuf_release", intf.ms_allowin, 1'b1);
        cyc();
        #1 chk1("rbuf_drain", intf.ms_to_ws_valid, 1'b0);

        cyc();
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = mk(3'b000, 1, 1, 0, 32'h0000_0020, 31);
        cyc();
        intf.es_to_ms_valid = 1'b0;
        intf.ws_flush       = 1'b1;
        #1 chk1("flush_no_out", intf.ms_to_ws_valid, 1'b0);
        cyc();
        intf.ws_flush = 1'b0;
        ins = mk(3'b000, 1, 1, 0, 32'h0000_0004, 32);
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = ins;
        sb.push_back(exp_bus(ins, 32'h7777_0004));
        #1 chk1("flush_cleared", intf.ms_allowin, 1'b1);
        chk32("flush_discard_one", 32'(dut.discard_cnt), 32'd1);
        cyc();
        intf.es_to_ms_valid    = 1'b0;
        intf.data_sram_data_ok = 1'b1;
        intf.data_sram_rdata   = 32'hBAD0_BAD0;
        #1 chk1("stale_dropped", intf.ms_to_ws_valid, 1'b0);
        chk1("stale_pending", intf.ms_fwd_bus[37], 1'b1);
        cyc();
        intf.data_sram_rdata = 32'h7777_0004;
        #1 chk32("discard_drained", 32'(dut.discard_cnt), 32'd0);
        chk1("own_data_out", intf.ms_to_ws_valid, 1'b1);
        cyc();
        intf.data_sram_data_ok = 1'b0;

        cyc();
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = mk(3'b000, 1, 1, 0, 32'h0000_0030, 33);
        cyc();
        intf.es_to_ms_valid    = 1'b0;
        intf.ws_flush          = 1'b1;
        intf.data_sram_data_ok = 1'b1;
        cyc();
        intf.ws_flush          = 1'b0;
        intf.data_sram_data_ok = 1'b0;
        #1 chk32("coincide_no_discard", 32'(dut.discard_cnt), 32'd0);
        chk1("coincide_cleared", intf.ms_allowin, 1'b1);

        cyc();
        intf.es_to_ms_valid = 1'b1;
        intf.es_to_ms_bus   = mk(3'b000, 1, 1, 0, 32'h0000_0040, 34);
        cyc();
        intf.es_to_ms_valid = 1'b0;
        #1 chk1("rst_wait_pending", intf.ms_fwd_bus[37], 1'b1);
        resetn = 1'b0;
        #1 chk1("async_rst_pending", intf.ms_fwd_bus[37], 1'b0);
        chk1("async_rst_allowin", intf.ms_allowin, 1'b1);
        cyc();
        resetn = 1'b1;
        cyc();
        #1 chk32("rst_discard", 32'(dut.discard_cnt), 32'd0);

        cyc();
        cyc();
        chk32("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
